// File: rtl/constants.sv
// Shared definitions for the load/store unit: data width, FSM state type and
// the request bundle presented by the execute stage.
package constants;

    localparam int unsigned DATA_WIDTH = 19;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        RESP
    } lsu_state_t;

    typedef struct packed {
        logic                  we;
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/address_bus_if.sv
// Data-memory word address bus.
interface address_bus_if #(
    parameter int unsigned ADDR_W = 10
);

    logic [ADDR_W-1:0] address;

    modport master (output address);
    modport slave  (input  address);

endinterface

// File: rtl/ctrl_bus_if.sv
// Data-memory control strobes: single-cycle write and read enables.
interface ctrl_bus_if;

    logic WR_EN_DM;
    logic RD_EN_DM;

    modport master (output WR_EN_DM, output RD_EN_DM);
    modport slave  (input  WR_EN_DM, input  RD_EN_DM);

endinterface

// File: rtl/data_bus_if.sv
// Data-memory write data (data_in) and read data (data_out) buses.
interface data_bus_if #(
    parameter int unsigned DATA_W = 19
);

    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (output data_in, input  data_out);
    modport slave  (input  data_in, output data_out);

endinterface

// File: rtl/lsu_rd_wait.sv
// Read-latency timer for the load/store unit. Loaded with RD_LATENCY on the
// edge that leaves READ, it counts down once per edge; capture_o is high
// during the cycle whose closing edge must sample data_out.
module lsu_rd_wait #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic capture_o
);

    logic [2:0] cnt_q;

    // Down-counter: reload on start, otherwise decrement until empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 3'd0;
        end else if (start_i) begin
            cnt_q <= 3'(RD_LATENCY);
        end else if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    assign capture_o = (cnt_q == 3'd1);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time from the execute stage,
// drives single-cycle data-memory enables, waits out the read latency and
// returns the result over a valid/ready response channel.
// Optional feature: define LSU_BOUNDS_CHECK_EN to reject addresses at or
// above MEM_DEPTH with resp_err; otherwise addresses wrap and resp_err is 0.
module load_store_unit
    import constants::*;
#(
    parameter int unsigned DATA_W     = DATA_WIDTH,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [DATA_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    ctrl_bus_if.master        ctrl_bus,
    address_bus_if.master     addr_bus,
    data_bus_if.master        data_bus
);

    localparam logic [DATA_W-1:0] MemDepthW = DATA_W'(MEM_DEPTH);

    lsu_state_t        state_q;
    lsu_req_t          req;
    logic              wr_en_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] data_in_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;
    logic              out_of_range;
    logic              rd_start;
    logic              capture;

    assign req = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i};

`ifdef LSU_BOUNDS_CHECK_EN
    assign out_of_range = (req.addr >= MemDepthW);
`else
    // Without the check, upper address bits are simply dropped (wrap).
    logic unused_cfg;
    assign out_of_range = 1'b0;
    assign unused_cfg   = ^{req.addr[DATA_WIDTH-1:ADDR_W], MemDepthW};
`endif

    assign rd_start = (state_q == READ);

    lsu_rd_wait #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (rd_start),
        .capture_o(capture)
    );

    // Request/response FSM with registered memory strobes and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            address_q    <= '0;
            data_in_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        if (out_of_range) begin
                            // Rejected: no memory access, respond immediately.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            resp_err_q <= 1'b0;
                            address_q  <= req.addr[ADDR_W-1:0];
                            if (req.we) begin
                                data_in_q <= req.wdata;
                                wr_en_q   <= 1'b1;
                                state_q   <= WRITE;
                            end else begin
                                rd_en_q <= 1'b1;
                                state_q <= READ;
                            end
                        end
                    end
                end
                WRITE: begin
                    wr_en_q      <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                    state_q      <= RESP;
                end
                READ: begin
                    rd_en_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        resp_rdata_q <= data_bus.data_out;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    wr_en_q      <= 1'b0;
                    rd_en_q      <= 1'b0;
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o       = (state_q == IDLE);
    assign resp_valid_o      = resp_valid_q;
    assign resp_rdata_o      = resp_rdata_q;
    assign resp_err_o        = resp_err_q;
    assign ctrl_bus.WR_EN_DM = wr_en_q;
    assign ctrl_bus.RD_EN_DM = rd_en_q;
    assign addr_bus.address  = address_q;
    assign data_bus.data_in  = data_in_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator between the CPU execute stage and `data_memory`. It accepts one load or store request at a time over a valid/ready handshake. It drives the data-memory control, address and data buses with single-cycle `WR_EN_DM`/`RD_EN_DM` pulses, waits out the memory read latency, and returns the result to the pipeline over a second valid/ready handshake.

## Interface
Parameters:
- `DATA_W`, 19: data word width; equals package `DATA_WIDTH`.
- `ADDR_W`, 10: data-memory address width.
- `MEM_DEPTH`, 1024: number of valid data-memory words; must be ≤ 2^ADDR_W.
- `RD_LATENCY`, 1: clock edges from the edge that samples `RD_EN_DM` high to `data_out` being valid; must be 1 to 4.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  DATA_W  word address from the CPU.
- `req_wdata`  in  DATA_W  store data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  pipeline accepts the response.
- `resp_rdata`  out  DATA_W  load data; 0 for stores.
- `resp_err`  out  1  access was rejected (see Configuration).
- `ctrl_bus`  ctrl_bus_if  unit drives `WR_EN_DM` and `RD_EN_DM`.
- `addr_bus`  address_bus_if  unit drives `address[ADDR_W-1:0]`.
- `data_bus`  data_bus_if  unit drives `data_in` and samples `data_out`.

## Operation
- State machine `lsu_state_t` has five states: IDLE, WRITE, READ, WAIT, RESP.
- `req_ready` is 1 only in IDLE. The unit is non-pipelined: there is never more than one outstanding request.
- IDLE, on `req_valid && req_ready`: latch `req_we`, `req_addr` and `req_wdata`.
  - Store goes to WRITE.
  - Load goes to READ.
- WRITE: `WR_EN_DM`=1 for exactly one cycle, with `address` and `data_in` valid in the same cycle. Next state is RESP.
- READ: `RD_EN_DM`=1 for exactly one cycle, with `address` valid. Next state is WAIT.
- WAIT: a down-counter loaded with `RD_LATENCY` counts edges. On the last edge, capture `data_out` into `resp_rdata` and go to RESP.
- RESP: `resp_valid`=1.
  - `resp_rdata` and `resp_err` are held stable until `resp_valid && resp_ready`.
  - On that handshake, go to IDLE. `resp_rdata` keeps its value.
- `WR_EN_DM` and `RD_EN_DM` are never both 1. Outside the WRITE and READ states, both are 0.
- `address` and `data_in` hold their last driven values between accesses.
- Address mapping: `address` = `req_addr[ADDR_W-1:0]`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, so `req_ready`=1;
  - `WR_EN_DM`=0, `RD_EN_DM`=0, `address`=0, `data_in`=0;
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- Reset asserted mid-operation: any pending access and response are discarded, and a write pulse in flight is cut short. After `rst_n` deasserts, the first acceptance can occur on the first rising edge.
- Latency, counting cycle 0 as the cycle after the acceptance edge:
  - Store: `WR_EN_DM` in cycle 0, `resp_valid` from cycle 1.
  - Load: `RD_EN_DM` in cycle 0, `resp_valid` from cycle 1+`RD_LATENCY`.
- Back-to-back requests: the next request can be accepted in the cycle after the response handshake. This gives a minimum spacing of 3 cycles per store and 3+`RD_LATENCY` cycles per load.
- `resp_ready` held low: the unit stays in RESP indefinitely with outputs stable, and `req_ready` stays 0.

## Configuration
- Macro `LSU_BOUNDS_CHECK_EN`.
- Defined:
  - A request with `req_addr` ≥ `MEM_DEPTH` issues no memory enable.
  - It goes directly from IDLE to RESP, so `resp_valid` is asserted in cycle 0.
  - The response carries `resp_err`=1 and `resp_rdata`=0.
  - In-range requests return `resp_err`=0.
- Undefined:
  - No check is performed; the address wraps modulo 2^ADDR_W.
  - `resp_err` is tied to 0.

## Structure
- Package `constants` holds:
  - `DATA_WIDTH` (19);
  - `lsu_state_t`, the state enum;
  - the struct `lsu_req_t`, containing `we`, `addr` and `wdata`.
- One natural sub-module, `lsu_rd_wait`: the `RD_LATENCY` down-counter plus the capture strobe for `data_out`. All other logic lives in `load_store_unit`.

## Test plan
- Store `req_addr`=10, `req_wdata`=19'h12345 -> a one-cycle `WR_EN_DM` pulse with `address`=10 and `data_in`=19'h12345; `resp_valid` in cycle 1. Then load address 10 -> `resp_rdata`=19'h12345 in cycle 2 (with `RD_LATENCY`=1).
- Store 19'h1A2B3 to address 20, then immediately load address 20 -> `resp_rdata`=19'h1A2B3. Also check that `req_ready` is 0 from acceptance until the response handshake.
- Load with `resp_ready` held low for 3 cycles -> `resp_valid` and `resp_rdata` stay stable for all 3 cycles; no second memory enable occurs.
- Deassert `rst_n` during WAIT of a load -> all outputs return to 0 immediately. After release, `req_ready`=1 and no stale `resp_valid` appears.
- With `LSU_BOUNDS_CHECK_EN`, load `req_addr`=19'h00400 -> no `RD_EN_DM` pulse; `resp_err`=1 and `resp_rdata`=0 in cycle 0. Without the macro, the same request reads address 0.
- With `RD_LATENCY`=3, load address 20 -> `resp_valid` first in cycle 4, carrying 19'h1A2B3.
